// File: rtl/collide_map_scanner.sv
// rtl/collide_map_scanner.sv - collision-map reader: snapshots the map and streams set-bit indices
// Ascending set-bit enumeration over valid/ready, one word examined per FETCH cycle.
module collide_map_scanner #(
  parameter int MAP_W  = 8192,
  parameter int WORD_W = 64,
  parameter int IDX_W  = 13
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               abort,
  input  logic [MAP_W-1:0]   map_in,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic [IDX_W-1:0]   idx_out,
  output logic               busy,
  output logic               done,
  output logic [IDX_W:0]     hit_count
);

  localparam int NW    = MAP_W / WORD_W;
  localparam int PTR_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAP_W-1:0]   r_shadow;
  logic [WORD_W-1:0]  r_work;
  logic [PTR_W-1:0]   r_ptr;
  logic [IDX_W:0]     r_hit;
  logic [WORD_W-1:0]  w_word;
  logic [WORD_W-1:0]  w_work_clr;
  logic [BIT_W-1:0]   w_lsb;
  logic               w_last;
  logic               w_xfer;

  assign w_word     = r_shadow[r_ptr*WORD_W +: WORD_W];
  assign w_last     = (r_ptr == PTR_W'(NW - 1));
  assign w_xfer     = (r_state == S_EMIT) && idx_ready;
  assign w_work_clr = r_work & (r_work - WORD_W'(1));

  // Scanning from the top down leaves the lowest set position in w_lsb.
  always_comb begin
    w_lsb = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (r_work[i]) w_lsb = BIT_W'(i);
    end
  end

  assign idx_valid = (r_state == S_EMIT);
  assign idx_out   = (r_state == S_EMIT) ? (IDX_W'(r_ptr * WORD_W) + IDX_W'(w_lsb)) : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign hit_count = r_hit;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (abort)             w_state_nxt = S_IDLE;
        else if (w_word != '0) w_state_nxt = S_EMIT;
        else if (w_last)       w_state_nxt = S_DONE;
      end
      S_EMIT: begin
        if (abort)                              w_state_nxt = S_IDLE;
        else if (w_xfer && w_work_clr == '0)    w_state_nxt = w_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_work   <= '0;
      r_ptr    <= '0;
      r_hit    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_shadow <= map_in;
            r_ptr    <= '0;
            r_hit    <= '0;
          end
        end
        S_FETCH: begin
          if (!abort) begin
            if (w_word != '0) r_work <= w_word;
            else if (!w_last) r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        S_EMIT: begin
          // A transfer coincident with abort still counts.
          if (w_xfer) begin
            r_work <= w_work_clr;
            r_hit  <= r_hit + (IDX_W + 1)'(1);
            if (!abort && w_work_clr == '0 && !w_last) r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collide_map_scanner.sv
// tb/tb_collide_map_scanner.sv - directed bench with set-bit list model and per-cycle compare
module tb_collide_map_scanner;

  localparam int MAP_W  = 8192;
  localparam int WORD_W = 64;
  localparam int IDX_W  = 13;
  localparam int NW     = MAP_W / WORD_W;

  logic               CLK = 0;
  logic               RST = 1;
  logic               start = 0;
  logic               abort = 0;
  logic [MAP_W-1:0]   map_in = '0;
  logic               idx_valid;
  logic               idx_ready = 0;
  logic [IDX_W-1:0]   idx_out;
  logic               busy;
  logic               done;
  logic [IDX_W:0]     hit_count;

  collide_map_scanner #(.MAP_W(MAP_W), .WORD_W(WORD_W), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .map_in(map_in),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_out(idx_out),
    .busy(busy), .done(done), .hit_count(hit_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: the scan must deliver exactly the ascending list of set bits of the captured map.
  int  m_q[$];
  int  acc_q[$];
  bit  m_busy = 0;
  int  m_hits = 0;
  bit  m_stall = 0;
  int  m_stall_idx = 0;
  int  start_cyc = 0;
  int  first_v_cyc = -1;
  int  done_lat = -1;
  int  done_cnt = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("hit_count", hit_count, m_hits);
      if (m_stall) begin
        chk("valid_held", idx_valid, 1);
        chk("idx_held", idx_out, m_stall_idx);
      end
      if (idx_valid) begin
        if (m_q.size() == 0) chk("valid_unexpected", idx_valid, 0);
        else chk("idx_out", idx_out, m_q[0]);
        if (first_v_cyc < 0) first_v_cyc = cyc - start_cyc;
      end
      if (done) begin
        chk("done_list_empty", m_q.size(), 0);
        chk("done_in_scan", m_busy, 1);
        done_cnt++;
        done_lat = cyc - start_cyc;
      end
      m_stall = 0;
      if (idx_valid && idx_ready) begin
        acc_q.push_back(int'(idx_out));
        if (m_q.size() > 0) void'(m_q.pop_front());
        m_hits++;
      end else if (idx_valid && !abort && !RST) begin
        m_stall = 1;
        m_stall_idx = int'(idx_out);
      end
      if (RST) begin
        m_busy = 0;
        m_hits = 0;
        m_q.delete();
      end else if (!m_busy) begin
        if (start && !abort) begin
          m_q.delete();
          for (int i = 0; i < MAP_W; i++) if (map_in[i]) m_q.push_back(i);
          m_busy = 1;
          m_hits = 0;
          acc_q.delete();
          first_v_cyc = -1;
          start_cyc = cyc + 1;
        end
      end else if (abort || done) begin
        m_busy = 0;
        m_q.delete();
      end
    end
  end

  task automatic do_start(input logic [MAP_W-1:0] m);
    @(posedge CLK); #1;
    map_in = m;
    start = 1;
    @(posedge CLK); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK); #1;
      if (done_cnt != d0) break;
    end
    repeat (3) @(negedge CLK);
    #1;
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge CLK); #1;
      if (idx_valid) break;
    end
    chk("valid_seen", idx_valid, 1);
  endtask

  logic [MAP_W-1:0] m;
  int d0;

  initial begin
    repeat (3) @(posedge CLK);
    #1 chk_en = 1;
    @(negedge CLK); #1;
    chk("rst_valid", idx_valid, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hits", hit_count, 0);
    @(posedge CLK); #1 RST = 0;

    // 1: empty map
    idx_ready = 1;
    do_start('0);
    wait_done(400);
    chk("t1_done_lat", done_lat, 128);
    chk("t1_no_valid", first_v_cyc, -1);
    chk("t1_hits", hit_count, 0);
    chk("t1_busy_after", busy, 0);

    // 2: sparse bits across words, map_in scribbled after capture
    m = '0; m[0] = 1; m[63] = 1; m[64] = 1; m[8191] = 1;
    do_start(m);
    map_in = '1;
    wait_done(400);
    chk("t2_count", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      chk("t2_idx0", acc_q[0], 0);
      chk("t2_idx1", acc_q[1], 63);
      chk("t2_idx2", acc_q[2], 64);
      chk("t2_idx3", acc_q[3], 8191);
    end
    chk("t2_hits", hit_count, 4);
    chk("t2_first_lat", first_v_cyc, 1);
    chk("t2_done_lat", done_lat, 132);

    // 3: full first word back-to-back
    m = '0; m[63:0] = '1;
    do_start(m);
    wait_done(400);
    chk("t3_count", acc_q.size(), 64);
    if (acc_q.size() == 64) for (int i = 0; i < 64; i++) chk("t3_idx", acc_q[i], i);
    chk("t3_hits", hit_count, 64);
    chk("t3_done_lat", done_lat, 192);

    // 4: backpressure on the first index
    idx_ready = 0;
    m = '0; m[5] = 1; m[9] = 1;
    do_start(m);
    wait_valid(20);
    chk("t4_stall_idx", idx_out, 5);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); @(negedge CLK); #1;
      chk("t4_stall_valid", idx_valid, 1);
      chk("t4_stall_idx", idx_out, 5);
    end
    @(posedge CLK); #1 idx_ready = 1;
    wait_done(400);
    chk("t4_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("t4_idx0", acc_q[0], 5);
      chk("t4_idx1", acc_q[1], 9);
    end
    chk("t4_done_lat", done_lat, 133);

    // 5: abort after two of four, then rescan with a map changed mid-scan
    m = '0; m[10] = 1; m[200] = 1; m[300] = 1; m[400] = 1;
    do_start(m);
    m = '0; m[7] = 1; m[100] = 1;
    map_in = m;
    d0 = done_cnt;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK); #1;
      if (acc_q.size() >= 2) break;
    end
    @(posedge CLK); #1 abort = 1;
    @(posedge CLK); #1 abort = 0;
    @(negedge CLK); #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", idx_valid, 0);
    chk("t5_hits", hit_count, 2);
    repeat (5) @(negedge CLK);
    #1 chk("t5_no_done", done_cnt - d0, 0);
    @(posedge CLK); #1 start = 1; abort = 1;
    @(posedge CLK); #1 start = 0; abort = 0;
    @(negedge CLK); #1 chk("t5_start_abort_idle", busy, 0);
    do_start(m);
    wait_done(400);
    chk("t5_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("t5_idx0", acc_q[0], 7);
      chk("t5_idx1", acc_q[1], 100);
    end
    chk("t5_hits2", hit_count, 2);

    // 6: start while busy ignored, then reset mid-EMIT
    idx_ready = 0;
    m = '0; m[20] = 1; m[21] = 1; m[22] = 1;
    do_start(m);
    wait_valid(20);
    @(posedge CLK); #1 start = 1; map_in = '1;
    @(posedge CLK); #1 start = 0;
    @(negedge CLK); #1;
    chk("t6_idx_kept", idx_out, 20);
    chk("t6_busy", busy, 1);
    chk("t6_hits", hit_count, 0);
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK); #1;
    chk("t6_rst_valid", idx_valid, 0);
    chk("t6_rst_idx", idx_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_hits", hit_count, 0);
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
